// File: rtl/mul_repadd_ctrl.sv
// -----------------------------------------------------------------------------
// mul_repadd_ctrl
// Control unit for a repeated-addition multiplier datapath. It loads the
// multiplicand and the multiplier from a shared bus, clears the product, then
// adds the multiplicand into the product once per cycle while decrementing the
// multiplier until the datapath reports that the multiplier is zero.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   start     operation request, acted on in IDLE (and in DONE for re-launch)
//   eqz       datapath: multiplier register is zero
//   ovf       datapath: carry-out of the current P+A sum
//   ldA       load multiplicand register from the bus
//   ldB       load multiplier register from the bus
//   clrP      synchronous clear of the product register
//   ldP       load product register with P+A (Mealy, follows ~eqz in ADD)
//   decB      decrement multiplier register (Mealy, follows ~eqz in ADD)
//   busy      high in every state except IDLE
//   done      one-cycle completion pulse
//   err       sticky error (overflow or iteration limit) for the last operation
//   iter_cnt  additions performed in the last or current operation
// -----------------------------------------------------------------------------
module mul_repadd_ctrl #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              eqz,
    input  logic              ovf,
    output logic              ldA,
    output logic              ldB,
    output logic              clrP,
    output logic              ldP,
    output logic              decB,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ONE_C      = ITER_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [ITER_W-1:0] w_iter_nxt;
    logic [ITER_W-1:0] w_iter_inc;
    logic              r_err;
    logic              w_err_nxt;

    assign w_iter_inc = r_iter_cnt + ONE_C;

    // Next-state, iteration counter and error flag computation
    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_A;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD_A: begin
                // Result of the previous operation is discarded only here,
                // so err/iter_cnt stay readable while the block idles.
                w_iter_nxt  = {ITER_W{1'b0}};
                w_err_nxt   = 1'b0;
                w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                if (eqz) begin
                    w_state_nxt = S_DONE;
                end else begin
                    // The add commits even when it overflows or hits the limit.
                    w_iter_nxt = w_iter_inc;
                    if (ovf || (w_iter_inc == MAX_ITER_C)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ADD;
                    end
                end
            end
            S_DONE: begin
                // A held start re-launches directly, giving one op per B+4 cycles.
                if (start) begin
                    w_state_nxt = S_LOAD_A;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and error registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_iter_cnt <= {ITER_W{1'b0}};
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_iter_cnt <= w_iter_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Output decode: all outputs derive from the state register, so an
    // asynchronous reset forces them low without waiting for a clock edge.
    always_comb begin
        ldA  = 1'b0;
        ldB  = 1'b0;
        clrP = 1'b0;
        ldP  = 1'b0;
        decB = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD_A: begin
                ldA = 1'b1;
            end
            S_LOAD_B: begin
                ldB  = 1'b1;
                clrP = 1'b1;
            end
            S_ADD: begin
                ldP  = ~eqz;
                decB = ~eqz;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err      = r_err;
    assign iter_cnt = r_iter_cnt;

endmodule
